hanoi_move_gen: RTL and testbench
=================================

Name: hanoi_move_gen

Overview:
Upstream move sequencer for the Tower of Hanoi tower model. After a start pulse it produces the optimal 2^S-1 move sequence that carries an S-disk tower from peg 0 to peg 2. Each move is a fr/to peg pair delivered over a valid/ready handshake. A built-in shadow model of the pegs flags any illegal move, so the downstream tower model and the formal cover have a known-good driver.

Parameters:
S, 4, number of disks; legal range 1..15.

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
start  input  1  one-cycle request to begin a new sequence; honoured only in IDLE or DONE
move_ready  input  1  downstream can accept a move this cycle
move_valid  output  1  fr/to hold a valid move
fr  output  2  source peg: 2'b00, 2'b01 or 2'b10; 2'b11 never driven
to  output  2  destination peg: same encoding as fr; fr != to whenever move_valid=1
move_cnt  output  S  number of moves accepted in the current sequence
done  output  1  sequence complete; held high until start or rst
illegal  output  1  sticky: the shadow model detected an illegal accepted move

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, move_valid=0, fr=0, to=0, move_cnt=0, done=0, illegal=0.
  - Shadow pegs after reset: peg0 = all ones, peg1 = 0, peg2 = 0.
  - rst mid-sequence aborts immediately; no partial move is recorded.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last move accepted--> DONE.
  - DONE --start--> RUN.
  - start is ignored while in RUN.
- Entering RUN (on the clock edge where start is sampled):
  - internal index m = 1, move_cnt = 0, done = 0, illegal = 0.
  - shadow pegs reinitialised to the reset values.
  - move_valid = 1 from the next cycle.
- Move formula, with m an (S+1)-bit index:
  - raw_fr = (m & (m-1)) mod 3
  - raw_to = ((m | (m-1)) + 1) mod 3
  - If S is even, pegs 1 and 2 are swapped on both fields after the mod. This makes the tower always end on peg 2.
- Output timing:
  - fr/to are registered and reflect m.
  - While move_valid=1 and move_ready=0, fr/to/move_valid stay stable (no change, no drop).
- Handshake: a move is accepted on a cycle with move_valid && move_ready. On accept:
  - move_cnt increments and m increments.
  - The shadow update is applied.
  - The next move is presented the following cycle, giving full throughput of one move per cycle when move_ready is held high.
- Completion:
  - On acceptance of move 2^S-1: move_valid drops to 0 on the next cycle, state goes to DONE, done=1.
  - move_cnt holds 2^S-1 while in DONE.
- Shadow model: three S-bit occupancy vectors; bit i means disk i is present on that peg, disk 0 is the smallest. The top disk of a peg is its lowest set bit.
  - An accepted move is legal iff the source peg is non-empty AND (the destination peg is empty OR top(src) < top(dst)).
  - A legal move clears the top bit from src and sets it in dst.
  - An illegal move sets illegal=1 (sticky until start or rst) and leaves the shadow pegs unchanged.
- Invariants:
  - illegal never rises for any S.
  - In DONE, shadow peg2 is all ones and peg0 = peg1 = 0.

Decomposition:
- Package hanoi_pkg holds:
  - typedef peg_t (2-bit) with constants PEG0=2'b00, PEG1=2'b01, PEG2=2'b10.
  - typedef enum gen_state_t {IDLE, RUN, DONE}.
  - function top_disk() returning the lowest set bit index; shared with the downstream model.
- Sub-module hanoi_mod3: combinational (S+1)-bit mod-3 reducer, instantiated twice (for fr and to).

Test Plan:
1. S=4, start, move_ready=1 always -> 15 consecutive moves, first four 0->1, 0->2, 1->2, 0->1; last 1->2; done=1 after move 15, move_cnt=15, illegal=0.
2. S=3, move_ready=1 -> 7 moves: 0->2, 0->1, 2->1, 0->2, 1->0, 1->2, 0->2; done=1.
3. S=4, move_ready toggled pseudo-randomly -> fr/to/move_valid stable on every stall cycle; same 15-move sequence as test 1; no duplicate or skipped move.
4. S=4, rst asserted after move 6 accepted -> next cycle all outputs at reset values; a fresh start replays the sequence from move 1.
5. Pulse start during RUN (at move 3) -> ignored, sequence unaffected; start in DONE -> restart with move_cnt=0 and done=0.
6. S=1 -> exactly one move 0->2, then done=1; fr=2'b11 or to=2'b11 never observed in any test.

Source files
------------

// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the Tower of Hanoi move generator and tower model.
//   peg_t       : 2-bit peg identifier (PEG0/PEG1/PEG2; 2'b11 unused)
//   gen_state_t : move generator FSM states
//   top_disk()  : index of the smallest disk on a peg (lowest set occupancy bit)
package hanoi_pkg;

    localparam int unsigned MAX_S = 15;

    typedef logic [1:0] peg_t;

    localparam peg_t PEG0 = 2'b00;
    localparam peg_t PEG1 = 2'b01;
    localparam peg_t PEG2 = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } gen_state_t;

    // Lowest set bit of an occupancy vector; returns 0 for an empty peg, so callers
    // must qualify the result with a non-empty test.
    function automatic logic [3:0] top_disk(input logic [MAX_S-1:0] occ);
        logic [3:0] idx;
        idx = '0;
        for (int i = MAX_S - 1; i >= 0; i--) begin
            if (occ[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hanoi_mod3.sv
// Combinational modulo-3 reducer.
//   val : W-bit unsigned operand
//   rem : val mod 3 (0, 1 or 2)
// Uses 2^i mod 3 = 1 for even i and 2 for odd i, folding the running sum as it goes.
module hanoi_mod3 #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] val,
    output logic [1:0]   rem
);

    logic [2:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < W; i++) begin
            if (val[i]) begin
                acc = acc + (((i % 2) == 0) ? 3'd1 : 3'd2);
                if (acc >= 3'd3) begin
                    acc = acc - 3'd3;
                end
            end
        end
        rem = acc[1:0];
    end

endmodule

// File: rtl/hanoi_move_gen.sv
// Tower of Hanoi optimal move sequencer with a shadow legality checker.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a new sequence (accepted in IDLE or DONE only)
//   move_ready : downstream accepts the presented move this cycle
//   move_valid : fr/to carry a move
//   fr, to     : source / destination peg of the presented move
//   move_cnt   : moves accepted in the current sequence
//   done       : whole 2^S-1 move sequence accepted
//   illegal    : sticky flag, an accepted move violated the disk ordering rule
module hanoi_move_gen
    import hanoi_pkg::*;
#(
    parameter int unsigned S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         move_ready,
    output logic         move_valid,
    output logic [1:0]   fr,
    output logic [1:0]   to,
    output logic [S-1:0] move_cnt,
    output logic         done,
    output logic         illegal
);

    localparam logic [S:0]   ONE_M  = (S + 1)'(1);
    localparam logic [S:0]   LAST_M = {1'b0, {S{1'b1}}};
    localparam logic [S-1:0] ONE_S  = S'(1);

    gen_state_t   state_q, state_d;
    logic [S:0]   m_q, m_d;
    logic [1:0]   fr_q, fr_d, to_q, to_d;
    logic [S-1:0] cnt_q, cnt_d;
    logic         ill_q, ill_d;
    logic [S-1:0] peg_q [3];
    logic [S-1:0] peg_d [3];

    logic         accept, last, load;
    logic [S:0]   and_term, or_term;
    logic [1:0]   raw_fr, raw_to;
    logic [S-1:0] src_occ, dst_occ, mask;
    logic         legal;

    // With an even disk count the canonical sequence ends on peg 1, so swap 1 and 2.
    function automatic logic [1:0] fix_peg(input logic [1:0] p);
        if ((S % 2) == 0 && p != PEG0) begin
            return (p == PEG1) ? PEG2 : PEG1;
        end
        return p;
    endfunction

    assign accept = (state_q == RUN) && move_ready;
    assign last   = (m_q == LAST_M);

    // Shadow legality of the currently presented move.
    always_comb begin
        src_occ = '0;
        dst_occ = '0;
        case (fr_q)
            PEG0:    src_occ = peg_q[0];
            PEG1:    src_occ = peg_q[1];
            PEG2:    src_occ = peg_q[2];
            default: src_occ = '0;
        endcase
        case (to_q)
            PEG0:    dst_occ = peg_q[0];
            PEG1:    dst_occ = peg_q[1];
            PEG2:    dst_occ = peg_q[2];
            default: dst_occ = '0;
        endcase
        legal = (src_occ != '0) &&
                ((dst_occ == '0) ||
                 (top_disk(MAX_S'(src_occ)) < top_disk(MAX_S'(dst_occ))));
        mask  = ONE_S << top_disk(MAX_S'(src_occ));
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        peg_d   = peg_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = RUN;
                    m_d      = ONE_M;
                    cnt_d    = '0;
                    ill_d    = 1'b0;
                    peg_d[0] = '1;
                    peg_d[1] = '0;
                    peg_d[2] = '0;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + ONE_S;
                    if (legal) begin
                        for (int p = 0; p < 3; p++) begin
                            if (2'(p) == fr_q) peg_d[p] = peg_q[p] & ~mask;
                            if (2'(p) == to_q) peg_d[p] = peg_q[p] | mask;
                        end
                    end else begin
                        ill_d = 1'b1;
                    end
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        m_d  = m_q + ONE_M;
                        load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // fr/to are computed from the next index so the registered pair always matches m_q.
    assign and_term = m_d & (m_d - ONE_M);
    assign or_term  = (m_d | (m_d - ONE_M)) + ONE_M;

    hanoi_mod3 #(.W(S + 1)) u_mod3_fr (
        .val (and_term),
        .rem (raw_fr)
    );

    hanoi_mod3 #(.W(S + 1)) u_mod3_to (
        .val (or_term),
        .rem (raw_to)
    );

    always_comb begin
        fr_d = fr_q;
        to_d = to_q;
        if (load) begin
            fr_d = fix_peg(raw_fr);
            to_d = fix_peg(raw_to);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            fr_q     <= PEG0;
            to_q     <= PEG0;
            cnt_q    <= '0;
            ill_q    <= 1'b0;
            peg_q[0] <= '1;
            peg_q[1] <= '0;
            peg_q[2] <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            fr_q    <= fr_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            for (int p = 0; p < 3; p++) begin
                peg_q[p] <= peg_d[p];
            end
        end
    end

    assign move_valid = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign fr         = fr_q;
    assign to         = to_q;
    assign move_cnt   = cnt_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_hanoi_move_gen.sv
module tb_hanoi_move_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       move_ready;
    logic [2:0] start;

    wire        vld [3];
    wire        dn  [3];
    wire        ill [3];
    wire  [1:0] frs [3];
    wire  [1:0] tos [3];
    wire  [3:0] cnt4;
    wire  [2:0] cnt3;
    wire  [0:0] cnt1;

    hanoi_move_gen #(.S(4)) u_s4 (
        .clk(clk), .rst(rst), .start(start[0]), .move_ready(move_ready),
        .move_valid(vld[0]), .fr(frs[0]), .to(tos[0]), .move_cnt(cnt4),
        .done(dn[0]), .illegal(ill[0])
    );

    hanoi_move_gen #(.S(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start[1]), .move_ready(move_ready),
        .move_valid(vld[1]), .fr(frs[1]), .to(tos[1]), .move_cnt(cnt3),
        .done(dn[1]), .illegal(ill[1])
    );

    hanoi_move_gen #(.S(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start[2]), .move_ready(move_ready),
        .move_valid(vld[2]), .fr(frs[2]), .to(tos[2]), .move_cnt(cnt1),
        .done(dn[2]), .illegal(ill[2])
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    // Model: expected move lists from a peg-stack simulation, plus per-instance progress.
    int sz [3] = '{4, 3, 1};
    int nmov [3];
    int exp_fr [3][16];
    int exp_to [3][16];
    int st [3] = '{0, 0, 0};   // 0 idle, 1 run, 2 done
    int k [3]  = '{0, 0, 0};   // moves accepted
    bit fresh [3] = '{1'b1, 1'b1, 1'b1};

    function automatic int cnt_of(input int i);
        if (i == 0) return int'(cnt4);
        if (i == 1) return int'(cnt3);
        return int'(cnt1);
    endfunction

    function automatic int low_bit(input int x);
        for (int b = 0; b < 16; b++) begin
            if (x[b]) return b;
        end
        return -1;
    endfunction

    task automatic chk(input int i, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst=%0d t=%0t got=%0d want=%0d", name, i, $time, act, exp);
        end
    endtask

    // Iterative solver: smallest disk cycles one way, odd steps take the only other legal move.
    task automatic gen(input int i);
        int n;
        int peg [3];
        int sp, dir, s, d, a, b, disk;
        n      = sz[i];
        peg[0] = (1 << n) - 1;
        peg[1] = 0;
        peg[2] = 0;
        sp     = 0;
        dir    = ((n % 2) == 0) ? 1 : 2;
        nmov[i] = (1 << n) - 1;
        for (int j = 0; j < nmov[i]; j++) begin
            if ((j % 2) == 0) begin
                s  = sp;
                d  = (sp + dir) % 3;
                sp = d;
            end else begin
                a = (sp + 1) % 3;
                b = (sp + 2) % 3;
                if (peg[a] == 0) begin
                    s = b; d = a;
                end else if (peg[b] == 0) begin
                    s = a; d = b;
                end else if (low_bit(peg[a]) < low_bit(peg[b])) begin
                    s = a; d = b;
                end else begin
                    s = b; d = a;
                end
            end
            disk   = low_bit(peg[s]);
            peg[s] = peg[s] & ~(1 << disk);
            peg[d] = peg[d] | (1 << disk);
            exp_fr[i][j] = s;
            exp_to[i][j] = d;
        end
        chk(i, "model_final_peg2", peg[2], (1 << n) - 1);
        chk(i, "model_final_peg0", peg[0] + peg[1], 0);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                st[i]    <= 0;
                k[i]     <= 0;
                fresh[i] <= 1'b1;
            end else if (st[i] == 1) begin
                if (move_ready) begin
                    k[i] <= k[i] + 1;
                    if (k[i] + 1 == nmov[i]) st[i] <= 2;
                end
            end else if (start[i]) begin
                st[i]    <= 1;
                k[i]     <= 0;
                fresh[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                chk(i, "move_valid", int'(vld[i]), int'(st[i] == 1));
                chk(i, "done", int'(dn[i]), int'(st[i] == 2));
                chk(i, "move_cnt", cnt_of(i), k[i]);
                chk(i, "illegal", int'(ill[i]), 0);
                chk(i, "fr_not_3", int'(frs[i] != 2'b11), 1);
                chk(i, "to_not_3", int'(tos[i] != 2'b11), 1);
                if (st[i] == 1) begin
                    chk(i, "fr", int'(frs[i]), exp_fr[i][k[i]]);
                    chk(i, "to", int'(tos[i]), exp_to[i][k[i]]);
                end else if (fresh[i]) begin
                    chk(i, "fr_reset", int'(frs[i]), 0);
                    chk(i, "to_reset", int'(tos[i]), 0);
                end
            end
        end
    end

    task automatic pulse(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // which: 0 = wait for k[i]==target while running, 1 = wait for done
    task automatic wait_for(input int i, input int which, input int target, input int budget);
        int n;
        bit hit;
        n   = 0;
        hit = (which == 0) ? (st[i] == 1 && k[i] == target) : (st[i] == 2);
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? (st[i] == 1 && k[i] == target) : (st[i] == 2);
        end
        chk(i, "wait_timeout", int'(hit), 1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) gen(i);

        // Pin the model with hand-derived moves.
        chk(0, "lit_s4_m1", exp_fr[0][0] * 10 + exp_to[0][0], 1);
        chk(0, "lit_s4_m2", exp_fr[0][1] * 10 + exp_to[0][1], 2);
        chk(0, "lit_s4_m3", exp_fr[0][2] * 10 + exp_to[0][2], 12);
        chk(0, "lit_s4_m4", exp_fr[0][3] * 10 + exp_to[0][3], 1);
        chk(0, "lit_s4_m15", exp_fr[0][14] * 10 + exp_to[0][14], 12);
        chk(1, "lit_s3_m1", exp_fr[1][0] * 10 + exp_to[1][0], 2);
        chk(1, "lit_s3_m2", exp_fr[1][1] * 10 + exp_to[1][1], 1);
        chk(1, "lit_s3_m3", exp_fr[1][2] * 10 + exp_to[1][2], 21);
        chk(1, "lit_s3_m4", exp_fr[1][3] * 10 + exp_to[1][3], 2);
        chk(1, "lit_s3_m5", exp_fr[1][4] * 10 + exp_to[1][4], 10);
        chk(1, "lit_s3_m6", exp_fr[1][5] * 10 + exp_to[1][5], 12);
        chk(1, "lit_s3_m7", exp_fr[1][6] * 10 + exp_to[1][6], 2);
        chk(2, "lit_s1_m1", exp_fr[2][0] * 10 + exp_to[2][0], 2);

        rst        = 1'b1;
        start      = '0;
        move_ready = 1'b1;
        @(posedge clk);
        #1 armed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Full-throughput sequences for S=4, S=3, S=1.
        pulse(0);
        wait_for(0, 1, 0, 100);
        chk(0, "t1_cnt", int'(cnt4), 15);
        chk(0, "t1_done", int'(dn[0]), 1);
        pulse(1);
        wait_for(1, 1, 0, 100);
        chk(1, "t2_cnt", int'(cnt3), 7);
        pulse(2);
        wait_for(2, 1, 0, 20);
        chk(2, "t6_cnt", int'(cnt1), 1);
        chk(2, "t6_done", int'(dn[2]), 1);

        // Restart from DONE with a stalling consumer.
        pulse(0);
        chk(0, "restart_cnt", int'(cnt4), 0);
        chk(0, "restart_done", int'(dn[0]), 0);
        for (int n = 0; n < 400 && st[0] != 2; n++) begin
            move_ready = 1'(($urandom_range(0, 1)));
            @(negedge clk);
        end
        chk(0, "t3_done_reached", st[0], 2);
        move_ready = 1'b1;
        @(negedge clk);

        // Start during RUN is ignored.
        pulse(0);
        wait_for(0, 0, 3, 50);
        pulse(0);
        wait_for(0, 1, 0, 100);
        chk(0, "t5_cnt", int'(cnt4), 15);

        // Reset mid-sequence, then replay.
        pulse(0);
        wait_for(0, 0, 6, 50);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk(0, "t4_valid", int'(vld[0]), 0);
        chk(0, "t4_cnt", int'(cnt4), 0);
        chk(0, "t4_fr", int'(frs[0]), 0);
        pulse(0);
        chk(0, "t4_first_fr", int'(frs[0]), 0);
        chk(0, "t4_first_to", int'(tos[0]), 1);
        wait_for(0, 1, 0, 100);
        @(negedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
